// File: rtl/control_unit_seq_if.sv
// Instruction/status bundle between the issuing datapath and the control sequencer.
// The master modport issues instructions and the slave modport sequences them.
interface control_unit_seq_if #(
  parameter int NREG = 4,
  parameter int OPW  = 4,
  parameter int FW   = 4,
  parameter int REPW = 3
);
  localparam int RIDX = (NREG > 1) ? $clog2(NREG) : 1;

  logic            execute_n;
  logic [OPW-1:0]  opcode;
  logic [RIDX-1:0] dst;
  logic [RIDX-1:0] src;
  logic [REPW-1:0] rep;

  logic [FW-1:0]   F;
  logic [1:0]      B_sel;
  logic [RIDX-1:0] src_sel;
  logic [NREG-1:0] write_en;
  logic            write_o;
  logic            write_cz;
  logic            busy;
  logic            done;
  logic            illegal;

  modport master (
    output execute_n, opcode, dst, src, rep,
    input  F, B_sel, src_sel, write_en, write_o, write_cz, busy, done, illegal
  );

  modport slave (
    input  execute_n, opcode, dst, src, rep,
    output F, B_sel, src_sel, write_en, write_o, write_cz, busy, done, illegal
  );
endinterface

// File: rtl/control_unit_seq.sv
// Multi-cycle control sequencer: latches one instruction on a falling edge of execute_n,
// then walks IDLE -> DECODE -> EXEC (rep+1 cycles) -> DONE, driving registered datapath controls.
module control_unit_seq #(
  parameter int NREG = 4,
  parameter int OPW  = 4,
  parameter int FW   = 4,
  parameter int REPW = 3
) (
  input  logic                clk,
  input  logic                rst,
  control_unit_seq_if.slave   bus
);
  localparam int RIDX = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [OPW-1:0] OP_HI_MASK = ~OPW'(4'hF);

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, DONE} state_t;

  state_t          state;
  logic            execute_n_q;
  logic [REPW-1:0] rep_cnt;

  // Strobe pattern captured at start and replayed on every EXEC cycle.
  logic [NREG-1:0] wen_q;
  logic            wo_q;
  logic            wcz_q;

  logic [FW-1:0]   f_r;
  logic [1:0]      b_sel_r;
  logic [RIDX-1:0] src_sel_r;
  logic [NREG-1:0] write_en_r;
  logic            write_o_r;
  logic            write_cz_r;
  logic            busy_r;
  logic            done_r;
  logic            illegal_r;

  logic [FW-1:0]   dec_f;
  logic [1:0]      dec_b_sel;
  logic [NREG-1:0] dec_wen;
  logic            dec_wo;
  logic            dec_wcz;
  logic            dec_illegal;
  logic            uses_dst;
  logic            start;

  assign start = (state == IDLE) && execute_n_q && !bus.execute_n;

  always_comb begin
    // NOTE: every decode output gets a default first so no path leaves one unassigned (no latch).
    dec_f       = '0;
    dec_b_sel   = 2'd0;
    dec_wo      = 1'b0;
    dec_wcz     = 1'b0;
    dec_illegal = 1'b0;
    uses_dst    = 1'b0;
    case (bus.opcode[3:0])
      4'h0: ;
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
        dec_f    = FW'(bus.opcode[3:0]);
        dec_wcz  = 1'b1;
        uses_dst = 1'b1;
      end
      4'h8: begin
        dec_f     = FW'(4'hF);
        dec_b_sel = 2'd1;
        uses_dst  = 1'b1;
      end
      4'h9: begin
        dec_f    = FW'(4'hF);
        uses_dst = 1'b1;
      end
      4'hA: begin
        dec_f  = FW'(4'hF);
        dec_wo = 1'b1;
      end
      4'hB: begin
        dec_f   = FW'(4'h2);
        dec_wcz = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
    // Out-of-range destinations only exist when NREG is not a power of two.
    if (|(bus.opcode & OP_HI_MASK) || (uses_dst && (32'(bus.dst) >= NREG)))
      dec_illegal = 1'b1;
    dec_wen = uses_dst ? (NREG'(1) << bus.dst) : '0;
  end

  // NOTE: all state and outputs update with <= so each register sees only pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      execute_n_q <= 1'b1;
      rep_cnt     <= '0;
      wen_q       <= '0;
      wo_q        <= 1'b0;
      wcz_q       <= 1'b0;
      f_r         <= '0;
      b_sel_r     <= 2'd0;
      src_sel_r   <= '0;
      write_en_r  <= '0;
      write_o_r   <= 1'b0;
      write_cz_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      illegal_r   <= 1'b0;
    end else begin
      execute_n_q <= bus.execute_n;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= DECODE;
            busy_r    <= 1'b1;
            illegal_r <= dec_illegal;
            rep_cnt   <= bus.rep;
            if (!dec_illegal) begin
              f_r       <= dec_f;
              b_sel_r   <= dec_b_sel;
              src_sel_r <= bus.src;
              wen_q     <= dec_wen;
              wo_q      <= dec_wo;
              wcz_q     <= dec_wcz;
            end
          end
        end
        DECODE: begin
          if (illegal_r) begin
            state  <= DONE;
            done_r <= 1'b1;
          end else begin
            state      <= EXEC;
            write_en_r <= wen_q;
            write_o_r  <= wo_q;
            write_cz_r <= wcz_q;
          end
        end
        EXEC: begin
          if (rep_cnt == '0) begin
            state      <= DONE;
            done_r     <= 1'b1;
            write_en_r <= '0;
            write_o_r  <= 1'b0;
            write_cz_r <= 1'b0;
          end else begin
            rep_cnt <= rep_cnt - 1'b1;
          end
        end
        DONE: begin
          state     <= IDLE;
          busy_r    <= 1'b0;
          done_r    <= 1'b0;
          illegal_r <= 1'b0;
          f_r       <= '0;
          b_sel_r   <= 2'd0;
          src_sel_r <= '0;
          wen_q     <= '0;
          wo_q      <= 1'b0;
          wcz_q     <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.F        = f_r;
  assign bus.B_sel    = b_sel_r;
  assign bus.src_sel  = src_sel_r;
  assign bus.write_en = write_en_r;
  assign bus.write_o  = write_o_r;
  assign bus.write_cz = write_cz_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.illegal  = illegal_r;
endmodule
